load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 32: pipeline and memory address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32: data width.
REQ-003 SHALL provide parameter MEM_BYTES, default 4096: implemented data memory size in bytes.
REQ-004 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port op_valid  input  1  MEM stage presents a memory op; held stable until op_done.
REQ-007 SHALL provide ports mem_read / mem_write  input  1 each  load / store request.
REQ-008 SHALL provide port funct3  input  3  access size and sign (RV32I load/store encoding).
REQ-009 SHALL provide port address  input  ADDR_WIDTH  byte address.
REQ-010 SHALL provide port write_data  input  DATA_WIDTH  store data, LSB-aligned.
REQ-011 SHALL provide port stall  output  1  freeze pipeline.
REQ-012 SHALL provide port op_done  output  1  one-cycle completion pulse.
REQ-013 SHALL provide port load_data  output  DATA_WIDTH  extended load result, valid with op_done.
REQ-014 SHALL provide ports exc_misalign / exc_fault  output  1 each  exception flags, valid with op_done.
REQ-015 SHALL provide ports dmem_req, dmem_we  output  1 each  memory request, write enable.
REQ-016 SHALL provide port dmem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] always 0.
REQ-017 SHALL provide ports dmem_be  output  4  byte enables; dmem_wdata  output  DATA_WIDTH  lane-positioned store data.
REQ-018 SHALL provide ports dmem_ack  input  1  request accepted/complete; dmem_rdata  input  DATA_WIDTH  read word, valid with dmem_ack.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, RESP.
REQ-020 IDLE: on op_valid & (mem_read | mem_write) SHALL register op (address, funct3, data, we = mem_write), then go to REQ, or to RESP on exception; mem_write SHALL win when both are set.
REQ-021 Misaligned SHALL mean halfword with address[0]=1, or word with address[1:0]!=0; address >= MEM_BYTES SHALL be a fault; misalign SHALL take priority over fault.
REQ-022 On exception SHALL go IDLE->RESP, never assert dmem_req, and set exactly one exception flag with op_done.
REQ-023 REQ: dmem_req=1 with dmem_we/addr/be/wdata registered and stable until the cycle dmem_ack=1; on ack SHALL capture the extracted result and go to RESP.
REQ-024 RESP: op_done=1 for exactly one cycle, then IDLE; minimum latency is accept at cycle N, dmem_req at N+1, op_done at N+2 with zero-wait ack.
REQ-025 stall SHALL equal op_valid & (mem_read | mem_write) & ~op_done, combinationally.
REQ-026 Store lanes SHALL be: SB be=0001<<address[1:0], wdata = byte replicated x4; SH be=0011 (address[1]=0) or 1100, wdata = halfword replicated x2; SW be=1111.
REQ-027 Load extraction SHALL select lane address[1:0] (byte) or address[1] (half); LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
REQ-028 Unlisted funct3 SHALL be treated as word (010) for loads and stores.
REQ-029 dmem_ack outside REQ SHALL be ignored.
REQ-030 load_data SHALL be 0 for stores and exceptions, and SHALL hold its value between ops.

Reset
REQ-031 While reset_n=0, state SHALL be IDLE and all outputs 0 (stall then follows inputs), asserted immediately, not at a clock edge.
REQ-032 Reset mid-REQ SHALL drop dmem_req at once; the aborted op SHALL produce no op_done; no op SHALL be accepted until the first rising edge after reset_n rises.

Verification
REQ-033 SW 0xDEADBEEF to 0x10, ack 2 cycles after req -> dmem_addr=0x10, be=1111, wdata=0xDEADBEEF held stable; op_done one cycle after ack.
REQ-034 LB at 0x13, rdata=0x80FF1234 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH at 0x12 -> 0xFFFF80FF.
REQ-035 SH 0x0000ABCD to 0x12 -> be=1100, wdata=0xABCDABCD; SB 0x5A to 0x11 -> be=0010, wdata=0x5A5A5A5A.
REQ-036 LW at 0x6 -> exc_misalign=1 with op_done at N+1, dmem_req never high; LW at 0x1000 (MEM_BYTES=4096) -> exc_fault=1.
REQ-037 Zero-wait ack back-to-back ops -> op_done at N+2 and N+5; stall low only in op_done cycles.
REQ-038 reset_n low during REQ -> dmem_req=0 same cycle, no op_done, and after release a fresh LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Handles RV32I sub-word lane placement, load extension, misalign/range exceptions.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  op_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall,
  output logic                  op_done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  exc_misalign,
  output logic                  exc_fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, byte_q, half_q, uns_q, mis_q, fault_q;
  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, load_q, load_ext;
  logic                  req_in, accept, is_byte, is_half, misalign, fault;
  logic [7:0]            lb;
  logic [15:0]           lh;

  assign req_in = op_valid & (mem_read | mem_write);
  assign accept = (state_q == IDLE) & req_in;

  // Stores only recognise 000/001 as sub-word; loads also take the unsigned forms.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (mem_write) begin
      is_byte = (funct3 == 3'b000);
      is_half = (funct3 == 3'b001);
    end else begin
      is_byte = (funct3[1:0] == 2'b00);
      is_half = (funct3[1:0] == 2'b01);
    end
  end

  assign misalign = (is_half & address[0]) | (~is_byte & ~is_half & (|address[1:0]));
  assign fault    = (address >= MEM_LIMIT);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = write_data;
    if (is_byte) begin
      be_d    = 4'b0001 << address[1:0];
      wdata_d = DATA_WIDTH'({4{write_data[7:0]}});
    end else if (is_half) begin
      be_d    = address[1] ? 4'b1100 : 4'b0011;
      wdata_d = DATA_WIDTH'({2{write_data[15:0]}});
    end
  end

  always_comb begin
    lb       = dmem_rdata[{lane_q, 3'b000} +: 8];
    lh       = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_ext = dmem_rdata;
    if (byte_q)
      load_ext = uns_q ? DATA_WIDTH'({24'b0, lb}) : DATA_WIDTH'({{24{lb[7]}}, lb});
    else if (half_q)
      load_ext = uns_q ? DATA_WIDTH'({16'b0, lh}) : DATA_WIDTH'({{16{lh[15]}}, lh});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_in) state_d = (misalign | fault) ? RESP : REQ;
      REQ:  if (dmem_ack) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req     = (state_q == REQ);
    op_done      = (state_q == RESP);
    dmem_we      = dmem_req & we_q;
    dmem_addr    = addr_q;
    dmem_be      = be_q;
    dmem_wdata   = wdata_q;
    load_data    = load_q;
    exc_misalign = op_done & mis_q;
    exc_fault    = op_done & fault_q;
    stall        = req_in & ~op_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      lane_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else if (accept) begin
      we_q    <= mem_write;
      byte_q  <= is_byte;
      half_q  <= is_half;
      uns_q   <= funct3[2];
      mis_q   <= misalign;
      fault_q <= ~misalign & fault;
      lane_q  <= address[1:0];
      addr_q  <= {address[ADDR_WIDTH-1:2], 2'b00};
      be_q    <= be_d;
      wdata_q <= wdata_d;
      if (misalign | fault) load_q <= '0;
    end else if ((state_q == REQ) && dmem_ack) begin
      load_q <= we_q ? '0 : load_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: lanes, extension,
// exceptions, back-to-back timing and asynchronous reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] address = '0, write_data = '0;
  logic        stall, op_done, exc_misalign, exc_fault;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .address(address), .write_data(write_data),
    .stall(stall), .op_done(op_done), .load_data(load_data),
    .exc_misalign(exc_misalign), .exc_fault(exc_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_op();
    op_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Drives one op to completion with an ack 'dly' cycles after the first request cycle.
  task automatic run_op(input string tag, input logic wr, input logic both,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int unsigned dly, input logic [31:0] rd,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eload,
                        input logic emis, input logic efault);
    op_valid = 1'b1; mem_write = wr; mem_read = ~wr | both;
    funct3 = f3; address = addr; write_data = wd;
    #1;
    chk({tag, ".stall_pre"}, 32'(stall), 32'd1);
    tick();
    if (emis | efault) begin
      chk({tag, ".req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".done"}, 32'(op_done), 32'd1);
      chk({tag, ".mis"}, 32'(exc_misalign), 32'(emis));
      chk({tag, ".fault"}, 32'(exc_fault), 32'(efault));
      chk({tag, ".load"}, load_data, 32'd0);
      chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    end else begin
      for (int unsigned i = 0; i <= dly; i++) begin
        chk({tag, ".req"}, 32'(dmem_req), 32'd1);
        chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
        chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        if (wr) begin
          chk({tag, ".be"}, 32'(dmem_be), 32'(ebe));
          chk({tag, ".wdata"}, dmem_wdata, ewd);
        end
        chk({tag, ".done_early"}, 32'(op_done), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        if (i == dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd;
        end
        tick();
      end
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      chk({tag, ".done"}, 32'(op_done), 32'd1);
      chk({tag, ".req_off"}, 32'(dmem_req), 32'd0);
      chk({tag, ".load"}, load_data, eload);
      chk({tag, ".mis"}, 32'(exc_misalign), 32'd0);
      chk({tag, ".fault"}, 32'(exc_fault), 32'd0);
      chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    end
    clear_op();
    tick();
    chk({tag, ".done_pulse"}, 32'(op_done), 32'd0);
    chk({tag, ".hold"}, load_data, eload);
  endtask

  initial begin
    // Reset state, asserted before any clock edge
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.done", 32'(op_done), 32'd0);
    chk("rst.load", load_data, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    op_valid = 1'b1; mem_write = 1'b1;
    #1;
    chk("rst.stall_follows", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("rst.no_accept", 32'(dmem_req), 32'd0);
    clear_op();
    #2 reset_n = 1'b1;
    tick();

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    tick();
    chk("idle_ack.done", 32'(op_done), 32'd0);
    chk("idle_ack.req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    //      tag     wr  both f3      addr          wdata         dly rdata         be       ewdata        eload         mis   flt
    run_op("sw",    1, 0, 3'b010, 32'h10,   32'hDEADBEEF, 2, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        0, 0);
    run_op("lb",    0, 0, 3'b000, 32'h13,   32'h0,        1, 32'h80FF1234, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0);
    run_op("lbu",   0, 0, 3'b100, 32'h13,   32'h0,        0, 32'h80FF1234, 4'b0000, 32'h0,        32'h00000080, 0, 0);
    run_op("lh",    0, 0, 3'b001, 32'h12,   32'h0,        0, 32'h80FF1234, 4'b0000, 32'h0,        32'hFFFF80FF, 0, 0);
    run_op("lhu",   0, 0, 3'b101, 32'h10,   32'h0,        0, 32'h80FF9234, 4'b0000, 32'h0,        32'h00009234, 0, 0);
    run_op("lw",    0, 0, 3'b010, 32'h14,   32'h0,        1, 32'h12345678, 4'b0000, 32'h0,        32'h12345678, 0, 0);
    run_op("sh",    1, 0, 3'b001, 32'h12,   32'h0000ABCD, 0, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0);
    run_op("sb",    1, 1, 3'b000, 32'h11,   32'h0000005A, 0, 32'hFFFFFFFF, 4'b0010, 32'h5A5A5A5A, 32'h0,        0, 0);
    run_op("sh_lo", 1, 0, 3'b001, 32'h20,   32'h11112222, 0, 32'h0,        4'b0011, 32'h22222222, 32'h0,        0, 0);
    run_op("lw_x",  0, 0, 3'b010, 32'h18,   32'h0,        0, 32'hCAFEF00D, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 0);
    run_op("lw_mis",0, 0, 3'b010, 32'h6,    32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    run_op("lw_flt",0, 0, 3'b010, 32'h1000, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 1);
    run_op("lh_pri",0, 0, 3'b001, 32'h1001, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    run_op("lb_top",0, 0, 3'b000, 32'hFFF,  32'h0,        0, 32'h7F000000, 4'b0000, 32'h0,        32'h0000007F, 0, 0);
    run_op("s_unl", 1, 0, 3'b011, 32'h24,   32'h11223344, 0, 32'h0,        4'b1111, 32'h11223344, 32'h0,        0, 0);
    run_op("sb_unl",1, 0, 3'b100, 32'h28,   32'h55667788, 0, 32'h0,        4'b1111, 32'h55667788, 32'h0,        0, 0);
    run_op("l_unl", 0, 0, 3'b110, 32'h24,   32'h0,        0, 32'h89ABCDEF, 4'b0000, 32'h0,        32'h89ABCDEF, 0, 0);
    run_op("l_unlm",0, 0, 3'b111, 32'h21,   32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);

    // Back-to-back zero-wait loads: op_done at N+2 and N+5
    op_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; address = 32'h40;
    tick();
    chk("b2b.a_req", 32'(dmem_req), 32'd1);
    chk("b2b.a_stall", 32'(stall), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hAAAA5555;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("b2b.a_done", 32'(op_done), 32'd1);
    chk("b2b.a_load", load_data, 32'hAAAA5555);
    address = 32'h44;
    #1;
    chk("b2b.a_stall_done", 32'(stall), 32'd0);
    tick();
    chk("b2b.gap_done", 32'(op_done), 32'd0);
    chk("b2b.gap_stall", 32'(stall), 32'd1);
    chk("b2b.gap_req", 32'(dmem_req), 32'd0);
    tick();
    chk("b2b.b_req", 32'(dmem_req), 32'd1);
    chk("b2b.b_addr", dmem_addr, 32'h44);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADC0DE;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("b2b.b_done", 32'(op_done), 32'd1);
    chk("b2b.b_load", load_data, 32'h0BADC0DE);
    clear_op();
    tick();

    // Reset during REQ aborts the op
    op_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; address = 32'h30;
    tick();
    chk("rreq.req", 32'(dmem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rreq.req_drop", 32'(dmem_req), 32'd0);
    chk("rreq.addr", dmem_addr, 32'd0);
    chk("rreq.stall", 32'(stall), 32'd1);
    dmem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rreq.no_done", 32'(op_done), 32'd0);
    end
    dmem_ack = 1'b0;
    clear_op();
    #2 reset_n = 1'b1;
    tick();
    chk("rreq.post_done", 32'(op_done), 32'd0);
    chk("rreq.post_req", 32'(dmem_req), 32'd0);
    run_op("lw_post", 0, 0, 3'b010, 32'h30, 32'h0, 0, 32'h13579BDF, 4'b0000, 32'h0, 32'h13579BDF, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
